// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Serves datapath reads and writes, fills whole lines on read misses and
// forwards every store to memory over a request/acknowledge bus.
module dcache_ctrl #(
  parameter int LINES = 4,
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cpu_read,
  input  logic                cpu_write,
  input  logic [15:0]         cpu_address,
  inout  wire  [15:0]         cpu_data,
  output logic                is_hit,
  output logic                is_miss,
  output logic                mem_access_done,
  output logic                mem_read,
  output logic                mem_write,
  output logic [15:0]         mem_address,
  output logic [15:0]         mem_wdata,
  input  logic [16*WORDS-1:0] mem_rdata,
  input  logic                mem_ack,
  output logic [15:0]         hit_count,
  output logic [15:0]         miss_count
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 16 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

  state_t                            state_q, state_d;
  logic [LINES-1:0]                  valid_q, valid_d;
  logic [LINES-1:0][TAG_W-1:0]       tag_q, tag_d;
  logic [LINES-1:0][WORDS-1:0][15:0] data_q, data_d;
  logic [15:0]                       addr_q, addr_d;
  logic [15:0]                       wdata_q, wdata_d;
  logic [15:0]                       hit_cnt_q, hit_cnt_d;
  logic [15:0]                       miss_cnt_q, miss_cnt_d;
  logic                              whit_q, whit_d;

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] fidx;
  logic [TAG_W-1:0] tag;
  logic             lookup_hit;
  logic [15:0]      rd_word;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign off        = cpu_address[OFF_W-1:0];
  assign idx        = cpu_address[OFF_W +: IDX_W];
  assign tag        = cpu_address[15 -: TAG_W];
  assign fidx       = addr_q[OFF_W +: IDX_W];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_word    = data_q[idx][off];

  // The read word goes on the shared bus only once the access is complete.
  assign cpu_data    = (cpu_read && mem_access_done) ? rd_word : 16'hzzzz;
  assign mem_read    = (state_q == FILL);
  assign mem_write   = (state_q == WRITE);
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

  // Handshake outputs; kept apart from next-state logic because the latter
  // samples cpu_data, which itself depends on mem_access_done.
  always_comb begin
    is_hit          = 1'b0;
    is_miss         = 1'b0;
    mem_access_done = 1'b1;
    case (state_q)
      IDLE: begin
        if (cpu_write || cpu_read) begin
          is_hit          = lookup_hit;
          is_miss         = !lookup_hit;
          // A write always stalls until memory has taken it.
          mem_access_done = !cpu_write && lookup_hit;
        end
      end
      FILL: begin
        is_miss         = 1'b1;
        mem_access_done = 1'b0;
      end
      WRITE: begin
        is_hit          = whit_q;
        is_miss         = !whit_q;
        mem_access_done = 1'b0;
      end
      default: ;
    endcase
  end

  // Next state, line updates, request latching and statistics.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    data_d     = data_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    whit_d     = whit_q;
    case (state_q)
      IDLE: begin
        if (cpu_write) begin
          addr_d  = cpu_address;
          wdata_d = cpu_data;
          whit_d  = lookup_hit;
          if (lookup_hit) begin
            data_d[idx][off] = cpu_data;
            hit_cnt_d        = sat_inc(hit_cnt_q);
          end else begin
            miss_cnt_d = sat_inc(miss_cnt_q);
          end
          state_d = WRITE;
        end else if (cpu_read) begin
          if (lookup_hit) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
          end else begin
            miss_cnt_d = sat_inc(miss_cnt_q);
            addr_d     = {cpu_address[15:OFF_W], {OFF_W{1'b0}}};
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        // Overwrites whatever line lived at this index.
        if (mem_ack) begin
          valid_d[fidx] = 1'b1;
          tag_d[fidx]   = addr_q[15 -: TAG_W];
          data_d[fidx]  = mem_rdata;
          state_d       = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) state_d = WDONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and storage registers; reset abandons any memory transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      whit_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      whit_q     <= whit_d;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a residency model predicts hit/miss,
// expected read data and expected memory requests; monitors compare.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [15:0] cpu_address = '0;
  wire  [15:0] cpu_data;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_wd = '0;
  logic        is_hit, is_miss, mem_access_done, mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata, hit_count, miss_count;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  assign cpu_data = tb_drv ? tb_wd : 16'hzzzz;

  dcache_ctrl #(.LINES(4), .WORDS(4)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .is_hit(is_hit),
    .is_miss(is_miss), .mem_access_done(mem_access_done), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } mreq_t;

  mreq_t       mq[$];
  logic [15:0] rq[$];
  logic [15:0] mem_m [0:65535];
  logic        m_valid [4];
  logic [11:0] m_tag [4];
  int          m_hit = 0, m_miss = 0;
  int          vectors = 0, errors = 0;
  int          lat_fixed = -1;
  int          stray_req = 0, stray_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Read-data monitor: every completed read must match the next expected word.
  always @(negedge clk) begin
    if (reset_n && cpu_read && !cpu_write && mem_access_done) begin
      if (rq.size() == 0) fail_now("rdata: completion with nothing expected");
      else check("rdata", {16'h0, cpu_data}, {16'h0, rq.pop_front()});
    end
  end

  // Memory responder and request monitor.
  mreq_t       r_e;
  int          r_lat;
  bit          r_abort;
  logic [15:0] r_base;
  initial begin
    forever begin
      @(negedge clk);
      if (stray_req != stray_done) begin
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        stray_done++;
      end else if (reset_n && (mem_read || mem_write)) begin
        check("mem_excl", {31'd0, mem_read & mem_write}, 32'd0);
        if (mq.size() == 0) begin
          fail_now("mem_req: unexpected request");
        end else begin
          r_e = mq.pop_front();
          check("mem_kind", {31'd0, mem_write}, {31'd0, r_e.wr});
          check("mem_addr", {16'h0, mem_address}, {16'h0, r_e.addr});
          if (r_e.wr) check("mem_wdata", {16'h0, mem_wdata}, {16'h0, r_e.data});
        end
        r_lat   = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
        r_abort = 1'b0;
        repeat (r_lat) begin
          @(negedge clk);
          if (!reset_n) r_abort = 1'b1;
        end
        if (!r_abort && reset_n) begin
          r_base = mem_address & 16'hFFFC;
          for (int w = 0; w < 4; w++) mem_rdata[w*16 +: 16] = mem_m[r_base + 16'(w)];
          mem_ack = 1'b1;
          @(negedge clk);
          mem_ack = 1'b0;
        end
      end
    end
  end

  task automatic do_read(input logic [15:0] a);
    int    ix;
    bit    hit;
    int    n;
    mreq_t r;
    ix  = int'(a[3:2]);
    hit = m_valid[ix] && (m_tag[ix] == a[15:4]);
    if (!hit) begin
      r.wr = 1'b0; r.addr = a & 16'hFFFC; r.data = 16'h0;
      mq.push_back(r);
      m_valid[ix] = 1'b1;
      m_tag[ix]   = a[15:4];
      m_miss++;
    end
    m_hit++;
    rq.push_back(mem_m[a]);
    cpu_address = a;
    cpu_read    = 1'b1;
    @(negedge clk);
    check("rd_is_hit", {31'd0, is_hit}, {31'd0, hit});
    check("rd_is_miss", {31'd0, is_miss}, {31'd0, !hit});
    n = 0;
    while (!mem_access_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mem_access_done) begin
      fail_now("rd_timeout");
      rq.delete();
      mq.delete();
    end else if (!hit) begin
      check("rd_refill_hit", {31'd0, is_hit}, 32'd1);
    end
    @(posedge clk);
    #1 cpu_read = 1'b0;
    check("hit_count", {16'h0, hit_count}, m_hit);
    check("miss_count", {16'h0, miss_count}, m_miss);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    int    ix;
    bit    hit;
    int    n;
    mreq_t r;
    ix  = int'(a[3:2]);
    hit = m_valid[ix] && (m_tag[ix] == a[15:4]);
    if (hit) m_hit++;
    else     m_miss++;
    mem_m[a] = d;
    r.wr = 1'b1; r.addr = a; r.data = d;
    mq.push_back(r);
    cpu_address = a;
    tb_wd       = d;
    tb_drv      = 1'b1;
    cpu_write   = 1'b1;
    @(negedge clk);
    check("wr_is_hit", {31'd0, is_hit}, {31'd0, hit});
    check("wr_is_miss", {31'd0, is_miss}, {31'd0, !hit});
    check("wr_done_req", {31'd0, mem_access_done}, 32'd0);
    n = 0;
    while (!mem_access_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!mem_access_done) begin
      fail_now("wr_timeout");
      mq.delete();
    end else begin
      check("wdone_no_mem_write", {31'd0, mem_write}, 32'd0);
    end
    @(posedge clk);
    #1;
    cpu_write = 1'b0;
    tb_drv    = 1'b0;
    check("hit_count", {16'h0, hit_count}, m_hit);
    check("miss_count", {16'h0, miss_count}, m_miss);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) mem_m[i] = 16'(i * 7) ^ 16'h5A3C;
    mem_m[0] = 16'h0001; mem_m[1] = 16'h0002; mem_m[2] = 16'h0003; mem_m[3] = 16'h0004;
    for (int i = 0; i < 4; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; end

    #1;
    check("rst_done", {31'd0, mem_access_done}, 32'd1);
    check("rst_hit_miss", {30'd0, is_hit, is_miss}, 32'd0);
    check("rst_mem_req", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_mem_addr", {16'h0, mem_address}, 32'd0);
    check("rst_counts", {hit_count, miss_count}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed scenarios.
    lat_fixed = 3;
    do_read(16'h0000);
    lat_fixed = -1;
    do_read(16'h0002);
    do_write(16'h0001, 16'hBEEF);
    do_read(16'h0001);
    do_write(16'h0100, 16'h1234);
    do_read(16'h0100);
    do_read(16'h0010);
    do_read(16'h0000);

    // Reset in the middle of a fill.
    lat_fixed   = 10;
    r_e         = '0;
    mq.push_back(mreq_t'({1'b0, 16'h0040, 16'h0000}));
    cpu_address = 16'h0040;
    cpu_read    = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_read && n < 10);
    if (!mem_read) fail_now("fill_never_started");
    #2;
    reset_n  = 1'b0;
    cpu_read = 1'b0;
    #1;
    check("rstfill_mem_read", {31'd0, mem_read}, 32'd0);
    check("rstfill_done", {31'd0, mem_access_done}, 32'd1);
    check("rstfill_counts", {hit_count, miss_count}, 32'd0);
    check("rstfill_addr", {16'h0, mem_address}, 32'd0);
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_hit  = 0;
    m_miss = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    lat_fixed = -1;
    stray_req++;
    n = 0;
    while (stray_done != stray_req && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (stray_done != stray_req) fail_now("stray_ack_timeout");
    @(negedge clk);
    check("stray_mem_req", {30'd0, mem_read, mem_write}, 32'd0);
    check("stray_counts", {hit_count, miss_count}, 32'd0);
    check("stray_done", {31'd0, mem_access_done}, 32'd1);
    @(posedge clk);
    #1;
    do_read(16'h0000);

    // Randomized traffic over a small address pool so lines are reused.
    for (int k = 0; k < 250; k++) begin
      a = 16'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a = a | 16'h1000;
      if ($urandom_range(0, 9) < 6) do_read(a);
      else do_write(a, 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    check("rq_drained", rq.size(), 32'd0);
    check("mq_drained", mq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller sitting between the pipelined datapath's data port (readM2/writeM2/address2/data2) and main memory. It answers datapath requests, drives the is_hit/is_miss/mem_access_done stall handshake the datapath consumes, and performs line fills and write-through stores on a request/acknowledge memory bus. It also keeps hit/miss counters for testbench statistics.

## Interface
- LINES, 4: number of cache lines; power of two, ≥2.
- WORDS, 4: 16-bit words per line; power of two.
- clk  input  1  rising-edge clock.
- reset_n  input  1  reset; asynchronous, active-low.
- cpu_read  input  1  datapath read request (readM2).
- cpu_write  input  1  datapath write request (writeM2).
- cpu_address  input  16  word address (address2).
- cpu_data  inout  16  driven by the cache only when cpu_read && mem_access_done, else high-Z; sampled as write data when cpu_write.
- is_hit  output  1  current request hits a valid line.
- is_miss  output  1  current request misses (held during fill/write-through).
- mem_access_done  output  1  0 = datapath must stall.
- mem_read  output  1  line-fill request, held until mem_ack.
- mem_write  output  1  single-word write request, held until mem_ack.
- mem_address  output  16  fill: line base {tag,index,0}; write: cpu_address.
- mem_wdata  output  16  write data, captured at request issue.
- mem_rdata  input  16*WORDS  fill line, word 0 in LSBs, valid when mem_ack.
- mem_ack  input  1  one-cycle completion pulse.
- hit_count  output  16  completed hitting accesses.
- miss_count  output  16  missing accesses.

## Operation
- Address split: offset = low log2(WORDS) bits, index = next log2(LINES), tag = remaining upper bits.
- Storage per line: valid, tag, WORDS data words. No dirty bit (write-through).
- States: IDLE, FILL, WRITE, WDONE.
- IDLE, no request: mem_access_done=1, is_hit=is_miss=0.
- IDLE, read hit: combinational; cpu_data = line word, is_hit=1, mem_access_done=1; hit_count+1 at clock edge. Stays IDLE.
- IDLE, read miss: is_miss=1, mem_access_done=0; miss_count+1; latch line address; go FILL.
- FILL: mem_read=1, is_miss=1, done=0. On mem_ack: write mem_rdata into line, set valid, store tag; go IDLE. The still-held request then hits next cycle (counted as a hit).
- IDLE, write (hit or miss): is_hit/is_miss reflect lookup, done=0; count hit or miss; latch address/data; on hit update the cached word in the same edge; go WRITE. Write miss does not allocate.
- WRITE: mem_write=1, done=0, is_hit/is_miss held from entry. On mem_ack go WDONE.
- WDONE: done=1 for exactly one cycle, no memory request, the held cpu_write is not re-processed, no counter change; go IDLE.
- cpu_read and cpu_write both high: treated as a write.
- Counters saturate at 16'hFFFF.

## Timing
- Reset (asynchronous): state IDLE, all valid bits 0, counters 0, mem_read=mem_write=0, mem_address=mem_wdata=0, is_hit=is_miss=0, mem_access_done=1, cpu_data high-Z. An in-flight fill or write is abandoned; a mem_ack arriving after reset release in IDLE is ignored.
- Read hit latency: 0 extra cycles (done in the request cycle).
- Read miss: 1 cycle into FILL, plus memory latency until mem_ack, plus 1 hit cycle; total stall = ack latency + 1 cycles.
- Write: request cycle + WRITE until mem_ack + WDONE; done rises only in WDONE.
- mem_read/mem_write are registered state outputs, never both high, and change only at clock edges or on reset.
- mem_ack outside FILL/WRITE is ignored.
- Index aliasing: a fill overwrites the line unconditionally; the old tag is lost.

## Test plan
- Reset, then read 0x0000 -> is_miss=1, mem_read with mem_address=0x0000; ack after 3 cycles with line {4,3,2,1} -> next cycle is_hit=1, cpu_data=0x0001, done=1; miss_count=1, hit_count=1.
- Read 0x0002 after that fill -> same-cycle hit, cpu_data=0x0003, no mem_read, hit_count=2.
- Write 0xBEEF to 0x0001 (hit) -> mem_write, mem_address=0x0001, mem_wdata=0xBEEF, done=0 until ack, done=1 for one cycle in WDONE; subsequent read 0x0001 hits and returns 0xBEEF.
- Write to 0x0100 (miss, same index as 0) -> memory write only, no fill; subsequent read 0x0100 misses, fill mem_address=0x0100.
- Read 0x0010 then 0x0000 (aliasing, LINES=4, WORDS=4) -> both miss; second fill replaces first; miss_count increments each time.
- Assert reset_n low during FILL -> mem_read drops immediately, valid bits cleared, counters 0, done=1; later mem_ack pulse causes no state change.
